// File: rtl/gesture_hold_ctrl_if.sv
// Gesture hold controller bus: raw gesture code in, held indicator and status out.
interface gesture_hold_ctrl_if #(
  parameter int unsigned CH_NUM = 4
);
  localparam int unsigned IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  logic [CH_NUM-1:0] gest_in;
  logic [CH_NUM-1:0] led_out;
  logic [IDX_W-1:0]  gest_idx;
  logic              gest_vld;
  logic              gest_evt;
  logic              hold_done;

  // Producer of gesture codes / consumer of the indicator.
  modport master (
    output gest_in,
    input  led_out, gest_idx, gest_vld, gest_evt, hold_done
  );

  // The controller itself.
  modport slave (
    input  gest_in,
    output led_out, gest_idx, gest_vld, gest_evt, hold_done
  );
endinterface

// File: rtl/gesture_hold_ctrl.sv
// Gesture indicator controller: turns a one-hot gesture code into a registered
// one-hot indicator held for HOLD_CNT cycles, with highest-index priority and
// pre-emption by a different gesture.
// Optional macro GESTURE_HOLD_RETRIG_EN: a repeat of the held gesture reloads
// the hold; without it the repeat is ignored.
module gesture_hold_ctrl #(
  parameter int unsigned CH_NUM   = 4,
  parameter int unsigned HOLD_CNT = 1000,
  parameter int unsigned CNT_W    = 26
) (
  input logic                sys_clk,
  input logic                sys_rst_n,
  gesture_hold_ctrl_if.slave bus
);
  localparam int unsigned IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CNT - 1);

`ifdef GESTURE_HOLD_RETRIG_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic [CH_NUM-1:0] gest_d;
  logic [CH_NUM-1:0] led_q;
  logic [IDX_W-1:0]  idx_q;
  logic              vld_q;
  logic              evt_q;
  logic              done_q;

  logic              new_evt;
  logic [IDX_W-1:0]  sel_idx;
  logic [CH_NUM-1:0] sel_oh;
  logic              load_hold;

  // Previous gesture code, used to fire only on a change.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      gest_d <= '0;
    end else begin
      gest_d <= bus.gest_in;
    end
  end

  // Highest set index wins for multi-hot codes; later iterations override.
  always_comb begin
    sel_idx = '0;
    sel_oh  = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      if (bus.gest_in[i]) begin
        sel_idx   = IDX_W'(i);
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
      end
    end
  end

  assign new_evt = (bus.gest_in != '0) && (bus.gest_in != gest_d);

  // In HOLD, a different gesture always pre-empts; the same one reloads only
  // when retriggering is enabled, otherwise it counts as no event at all.
  assign load_hold = new_evt && ((sel_idx != idx_q) || RETRIG);

  // Main FSM with registered outputs; events beat expiry in the same cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state  <= StIdle;
      cnt    <= '0;
      led_q  <= '0;
      idx_q  <= '0;
      vld_q  <= 1'b0;
      evt_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      evt_q  <= 1'b0;
      done_q <= 1'b0;
      unique case (state)
        StIdle: begin
          if (new_evt) begin
            state <= StHold;
            led_q <= sel_oh;
            idx_q <= sel_idx;
            vld_q <= 1'b1;
            cnt   <= '0;
            evt_q <= 1'b1;
          end
        end
        StHold: begin
          if (load_hold) begin
            led_q <= sel_oh;
            idx_q <= sel_idx;
            cnt   <= '0;
            evt_q <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            state  <= StIdle;
            led_q  <= '0;
            vld_q  <= 1'b0;
            cnt    <= '0;
            done_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.led_out   = led_q;
  assign bus.gest_idx  = idx_q;
  assign bus.gest_vld  = vld_q;
  assign bus.gest_evt  = evt_q;
  assign bus.hold_done = done_q;

endmodule

// File: tb/tb_gesture_hold_ctrl.sv
// Self-checking bench for gesture_hold_ctrl: directed scenarios followed by
// randomized gesture traffic, compared against a remaining-cycles model.
module tb_gesture_hold_ctrl;
  localparam int unsigned CH_NUM   = 4;
  localparam int unsigned HOLD_CNT = 8;
  localparam int unsigned CNT_W    = 4;

`ifdef GESTURE_HOLD_RETRIG_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;

  gesture_hold_ctrl_if #(.CH_NUM(CH_NUM)) bus ();

  gesture_hold_ctrl #(
    .CH_NUM  (CH_NUM),
    .HOLD_CNT(HOLD_CNT),
    .CNT_W   (CNT_W)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: which channel is shown and how many cycles of display remain.
  int       m_idx  = 0;
  int       m_rem  = 0;
  int       m_prev = 0;
  bit       m_evt  = 1'b0;
  bit       m_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int highest(input int code);
    int h = -1;
    for (int i = 0; i < int'(CH_NUM); i++) if (code[i]) h = i;
    return h;
  endfunction

  task automatic model_reset();
    m_idx = 0; m_rem = 0; m_prev = 0; m_evt = 0; m_done = 0;
  endtask

  // One clock edge of the spec's rules, expressed as a countdown of display cycles.
  task automatic model_edge(input int code);
    bit ev;
    int s;
    ev = (code != 0) && (code != m_prev);
    s  = highest(code);
    m_evt = 0; m_done = 0;
    if (m_rem > 0) begin
      if (ev && (s != m_idx || RETRIG)) begin
        m_idx = s; m_rem = HOLD_CNT; m_evt = 1;
      end else begin
        m_rem--;
        if (m_rem == 0) m_done = 1;
      end
    end else if (ev) begin
      m_idx = s; m_rem = HOLD_CNT; m_evt = 1;
    end
    m_prev = code;
  endtask

  task automatic compare_all(input string tag);
    int exp_led;
    exp_led = (m_rem > 0) ? (1 << m_idx) : 0;
    check({tag, ".led"},  32'(bus.led_out),   32'(exp_led));
    check({tag, ".idx"},  32'(bus.gest_idx),  32'(m_idx));
    check({tag, ".vld"},  32'(bus.gest_vld),  32'(m_rem > 0));
    check({tag, ".evt"},  32'(bus.gest_evt),  32'(m_evt));
    check({tag, ".done"}, 32'(bus.hold_done), 32'(m_done));
  endtask

  task automatic step(input int code, input string tag);
    @(negedge sys_clk);
    bus.gest_in = CH_NUM'(code);
    @(posedge sys_clk);
    model_edge(code);
    #1;
    compare_all(tag);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".led"},  32'(bus.led_out),   0);
    check({tag, ".idx"},  32'(bus.gest_idx),  0);
    check({tag, ".vld"},  32'(bus.gest_vld),  0);
    check({tag, ".evt"},  32'(bus.gest_evt),  0);
    check({tag, ".done"}, 32'(bus.hold_done), 0);
  endtask

  // Reset asserted between edges must clear outputs without waiting for a clock.
  task automatic reset_mid(input string tag);
    @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1 check_zero({tag, ".async"});
    model_reset();
    @(posedge sys_clk);
    #1 check_zero({tag, ".held"});
    @(negedge sys_clk);
    bus.gest_in = '0;
    sys_rst_n = 1'b1;
  endtask

  int cur;
  int dwell;
  int r;

  initial begin
    // Reset with a gesture present: nothing may be latched.
    bus.gest_in = 4'b0100;
    sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1 check_zero("reset");
    @(negedge sys_clk);
    bus.gest_in = '0;
    sys_rst_n = 1'b1;
    model_reset();
    step(0, "post_reset");
    step(0, "post_reset");

    // Single one-cycle event, then full hold and expiry.
    step(4'b0010, "single");
    repeat (11) step(0, "single_hold");

    // Multi-hot held steady: one event, one expiry, no re-fire.
    repeat (20) step(4'b0101, "multi");
    step(0, "multi_end");

    // Pre-empt on hold cycle 3.
    step(4'b0001, "preempt_a");
    repeat (2) step(0, "preempt_gap");
    step(4'b1000, "preempt_b");
    repeat (10) step(0, "preempt_hold");

    // Same channel again during the hold.
    step(4'b0010, "retrig_a");
    repeat (4) step(0, "retrig_gap");
    step(4'b0010, "retrig_b");
    repeat (14) step(0, "retrig_hold");

    // Reset on hold cycle 4.
    step(4'b0100, "rst_mid_ev");
    repeat (3) step(0, "rst_mid_hold");
    reset_mid("rst_mid");
    repeat (3) step(0, "rst_mid_after");

    // Randomized traffic with occasional asynchronous resets.
    cur = 0;
    dwell = 0;
    for (int i = 0; i < 3000; i++) begin
      if (dwell == 0) begin
        r = $urandom_range(0, 9);
        if (r < 3)      cur = 0;
        else if (r < 8) cur = 1 << $urandom_range(0, CH_NUM - 1);
        else            cur = $urandom_range(0, (1 << CH_NUM) - 1);
        dwell = $urandom_range(1, 12);
      end
      dwell--;
      if (m_rem > 0 && $urandom_range(0, 299) == 0) begin
        reset_mid("rand_rst");
        cur = 0;
        dwell = 0;
      end else begin
        step(cur, "rand");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
